// File: rtl/peripheral_pkg.sv
// Shared register map and TCON bit positions for the peripheral bus responder.
package peripheral_pkg;
  localparam logic [31:0] OFS_TH      = 32'h00;
  localparam logic [31:0] OFS_TL      = 32'h04;
  localparam logic [31:0] OFS_TCON    = 32'h08;
  localparam logic [31:0] OFS_LED     = 32'h0C;
  localparam logic [31:0] OFS_DIGI    = 32'h10;
  localparam logic [31:0] OFS_SYSTICK = 32'h14;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_ST = 2;

  // Decoded write strobes handed to the timer core.
  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
  } timer_we_t;
endpackage

// File: rtl/peripheral_bus_if.sv
// CPU data-bus view of device space: strobes, address, write data, read data.
interface peripheral_bus_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemBus_Address;
  logic [31:0] MemBus_Write_Data;
  logic [31:0] Device_Read_Data;

  modport master (
    output MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
    input  Device_Read_Data
  );

  modport slave (
    input  MemRead, MemWrite, MemBus_Address, MemBus_Write_Data,
    output Device_Read_Data
  );
endinterface

// File: rtl/peripheral_bus_timer_core.sv
// Reloadable 32-bit up-counter with sticky overflow status and level interrupt.
module timer_core
  import peripheral_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  timer_we_t   we,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);
  logic ovf;
  assign ovf = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (we.th) th <= wdata;
      // CPU write to TL beats the reload; reload always uses the pre-edge TH.
      if (we.tl)                tl <= wdata;
      else if (tcon[TCON_EN])   tl <= ovf ? th : tl + 32'd1;
      if (we.tcon) tcon <= wdata[2:0];
      // Overflow setting status wins over a same-cycle software clear.
      if (ovf && tcon[TCON_IE]) tcon[TCON_ST] <= 1'b1;
    end
  end

  assign irq = tcon[TCON_ST] & tcon[TCON_IE];
endmodule

// File: rtl/peripheral_bus.sv
// Device-space responder: address decode, LED/DIGI/SYSTICK registers, read mux.
module peripheral_bus
  import peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic            clk,
  input  logic            reset,
  peripheral_bus_if.slave bus,
  output logic            irq,
  output logic [7:0]      leds,
  output logic [11:0]     digi
);
  logic [31:0] addr;
  logic        aligned;
  logic        hit_th, hit_tl, hit_tcon, hit_led, hit_digi, hit_systick;
  logic [31:0] systick;
  logic [31:0] th, tl;
  logic [2:0]  tcon;
  logic [31:0] rdata;
  timer_we_t   we;

  assign addr        = bus.MemBus_Address;
  assign aligned     = (addr[1:0] == 2'b00);
  assign hit_th      = aligned && (addr == BASE_ADDR + OFS_TH);
  assign hit_tl      = aligned && (addr == BASE_ADDR + OFS_TL);
  assign hit_tcon    = aligned && (addr == BASE_ADDR + OFS_TCON);
  assign hit_led     = aligned && (addr == BASE_ADDR + OFS_LED);
  assign hit_digi    = aligned && (addr == BASE_ADDR + OFS_DIGI);
  assign hit_systick = aligned && (addr == BASE_ADDR + OFS_SYSTICK);

  assign we.th   = bus.MemWrite && hit_th;
  assign we.tl   = bus.MemWrite && hit_tl;
  assign we.tcon = bus.MemWrite && hit_tcon;

  timer_core u_timer (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .wdata (bus.MemBus_Write_Data),
    .th    (th),
    .tl    (tl),
    .tcon  (tcon),
    .irq   (irq)
  );

  // SYSTICK is read-only: a hitting write is simply not decoded into it.
  always_ff @(posedge clk) begin
    if (reset) begin
      leds    <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
      if (bus.MemWrite && hit_led)  leds <= bus.MemBus_Write_Data[7:0];
      if (bus.MemWrite && hit_digi) digi <= bus.MemBus_Write_Data[11:0];
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      if      (hit_th)      rdata = th;
      else if (hit_tl)      rdata = tl;
      else if (hit_tcon)    rdata = {29'd0, tcon};
      else if (hit_led)     rdata = {24'd0, leds};
      else if (hit_digi)    rdata = {20'd0, digi};
      else if (hit_systick) rdata = systick;
    end
  end

  assign bus.Device_Read_Data = rdata;
endmodule

// File: tb/tb_peripheral_bus.sv
// Directed bench for peripheral_bus: register map, timer overflow/irq, collisions, decode misses.
module tb_peripheral_bus;
  import peripheral_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digi;
  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] tcnt;

  peripheral_bus_if bus ();

  peripheral_bus #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq),
    .leds  (leds),
    .digi  (digi)
  );

  always #5 clk = ~clk;

  // Reference count of edges since reset was last released.
  always @(posedge clk) begin
    if (reset) tcnt <= '0;
    else       tcnt <= tcnt + 32'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [31:0] data);
    bus.MemWrite          = 1'b1;
    bus.MemBus_Address    = BASE + ofs;
    bus.MemBus_Write_Data = data;
    step();
    bus.MemWrite          = 1'b0;
  endtask

  // Combinational read inside the current cycle; advances 1 time unit.
  task automatic rd(input string tag, input logic [31:0] ofs, input logic [31:0] exp);
    bus.MemRead        = 1'b1;
    bus.MemBus_Address = BASE + ofs;
    #1;
    chk(tag, bus.Device_Read_Data, exp);
    bus.MemRead        = 1'b0;
  endtask

  initial begin
    reset                 = 1'b1;
    bus.MemRead           = 1'b0;
    bus.MemWrite          = 1'b0;
    bus.MemBus_Address    = BASE;
    bus.MemBus_Write_Data = '0;
    repeat (3) step();
    reset = 1'b0;

    #1;
    chk("rst_idle_rdata", bus.Device_Read_Data, 32'h0);
    chk("rst_leds", {24'd0, leds}, 32'h0);
    chk("rst_digi", {20'd0, digi}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    rd("rst_th",   OFS_TH,   32'h0);
    rd("rst_tl",   OFS_TL,   32'h0);
    rd("rst_tcon", OFS_TCON, 32'h0);
    step();
    rd("rst_led",  OFS_LED,  32'h0);
    rd("rst_digi_rd", OFS_DIGI, 32'h0);
    step();
    rd("systick_after_2", OFS_SYSTICK, 32'd2);
    chk("systick_model", tcnt, 32'd2);

    // First overflow with interrupt enabled.
    wr(OFS_TH, 32'hFFFF_FFF0);
    wr(OFS_TL, 32'hFFFF_FFFD);
    wr(OFS_TCON, 32'h3);
    rd("tl_loaded", OFS_TL, 32'hFFFF_FFFD);
    step(); step();
    rd("tl_at_max", OFS_TL, 32'hFFFF_FFFF);
    chk("irq_before_ovf", {31'd0, irq}, 32'h0);
    step();
    rd("tl_reloaded", OFS_TL, 32'hFFFF_FFF0);
    chk("irq_after_ovf", {31'd0, irq}, 32'h1);
    rd("tcon_status", OFS_TCON, 32'h7);

    // Software clear, then second wrap.
    wr(OFS_TCON, 32'h3);
    chk("irq_cleared", {31'd0, irq}, 32'h0);
    rd("tl_after_clear", OFS_TL, 32'hFFFF_FFF1);
    repeat (14) step();
    rd("tl_max_again", OFS_TL, 32'hFFFF_FFFF);
    step();
    chk("irq_reassert", {31'd0, irq}, 32'h1);
    rd("tl_rewrap", OFS_TL, 32'hFFFF_FFF0);

    // TL write collides with overflow: write wins, status still set.
    wr(OFS_TCON, 32'h3);
    repeat (14) step();
    wr(OFS_TL, 32'h1234);
    rd("tl_write_wins", OFS_TL, 32'h1234);
    rd("tcon_st_on_tl_wr", OFS_TCON, 32'h7);
    chk("irq_on_tl_wr", {31'd0, irq}, 32'h1);

    // TCON clear collides with overflow: set wins.
    wr(OFS_TCON, 32'h3);
    chk("irq_clear2", {31'd0, irq}, 32'h0);
    wr(OFS_TL, 32'hFFFF_FFFE);
    step();
    wr(OFS_TCON, 32'h3);
    rd("tcon_set_wins", OFS_TCON, 32'h7);
    rd("tl_reload_tcon_wr", OFS_TL, 32'hFFFF_FFF0);

    // TH write at overflow: reload takes the old TH.
    wr(OFS_TL, 32'hFFFF_FFFE);
    step();
    wr(OFS_TH, 32'h100);
    rd("tl_old_th", OFS_TL, 32'hFFFF_FFF0);
    rd("th_new", OFS_TH, 32'h100);
    wr(OFS_TCON, 32'h0);
    rd("tcon_off", OFS_TCON, 32'h0);

    // LED / DIGI truncation and read-during-write.
    wr(OFS_LED, 32'hFFFF_FFA5);
    chk("leds_a5", {24'd0, leds}, 32'hA5);
    rd("led_rd", OFS_LED, 32'hA5);
    wr(OFS_DIGI, 32'h0000_1E3F);
    chk("digi_e3f", {20'd0, digi}, 32'hE3F);
    rd("digi_rd", OFS_DIGI, 32'hE3F);
    bus.MemRead           = 1'b1;
    bus.MemWrite          = 1'b1;
    bus.MemBus_Address    = BASE + OFS_LED;
    bus.MemBus_Write_Data = 32'h5A;
    #1;
    chk("rw_old_value", bus.Device_Read_Data, 32'hA5);
    step();
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    chk("rw_new_leds", {24'd0, leds}, 32'h5A);

    // SYSTICK ignores writes.
    wr(OFS_SYSTICK, 32'h0);
    rd("systick_ro", OFS_SYSTICK, tcnt);

    // Misaligned and out-of-map accesses hit nothing.
    wr(32'h02, 32'hDEAD);
    wr(32'h18, 32'hDEAD);
    chk("miss_leds", {24'd0, leds}, 32'h5A);
    chk("miss_digi", {20'd0, digi}, 32'hE3F);
    rd("miss_th", OFS_TH, 32'h100);
    rd("miss_rd_02", 32'h02, 32'h0);
    rd("miss_rd_18", 32'h18, 32'h0);

    // Reset mid-count stops the timer and clears everything.
    wr(OFS_TCON, 32'h3);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd("mid_rst_tcon", OFS_TCON, 32'h0);
    rd("mid_rst_tl", OFS_TL, 32'h0);
    chk("mid_rst_leds", {24'd0, leds}, 32'h0);
    chk("mid_rst_irq", {31'd0, irq}, 32'h0);
    step();
    rd("mid_rst_tl_stopped", OFS_TL, 32'h0);
    rd("mid_rst_systick", OFS_SYSTICK, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/peripheral_bus.md
# peripheral_bus

Memory-mapped device responder on the CPU's data bus: it answers the CPU's device-space loads and stores. It holds the LED register, the seven-segment digit register, a reloadable 32-bit timer with interrupt, and a free-running system tick counter. It sits beside the data memory. The CPU's `Device_Read_Data` input is driven from here whenever the bus address falls in device space.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: byte address of the first device register.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clk`.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `MemRead` input 1: CPU load strobe.
- `MemWrite` input 1: CPU store strobe; the CPU's `MemWrite_origin` connects here.
- `MemBus_Address` input 32: byte address, word-aligned.
- `MemBus_Write_Data` input 32: store data.
- `Device_Read_Data` output 32: load data, combinational.
- `irq` output 1: timer interrupt request, level-sensitive.
- `leds` output 8: LED register.
- `digi` output 12: seven-segment register; [11:8] are the digit selects, [7:0] are the segments plus decimal point.

## Operation
- Register map, as byte offsets from `BASE_ADDR`:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: count value, R/W.
  - 0x08 TCON: [0] enable, [1] interrupt enable, [2] status; R/W; bits [31:3] read 0.
  - 0x0C LED: [7:0] R/W.
  - 0x10 DIGI: [11:0] R/W.
  - 0x14 SYSTICK: read-only; writes are ignored.
- Decode:
  - A register hits only on an exact 32-bit address match.
  - Any address with [1:0] != 0 hits nothing.
  - Any address outside the six registers hits nothing.
- Write:
  - When `MemWrite` is high and the address hits, the register loads `MemBus_Write_Data` (truncated to the register's width) at the next edge.
  - Non-hitting writes change nothing.
- Read:
  - `Device_Read_Data` = the hit register, zero-extended, when `MemRead` is high and the address hits.
  - Otherwise `Device_Read_Data` = 0.
  - Reads have no side effects.
- Timer, when TCON[0] = 1, each cycle:
  - If TL == 32'hFFFF_FFFF: TL <= TH, and if TCON[1] = 1, TCON[2] <= 1.
  - Otherwise TL <= TL + 1.
  - Arithmetic is unsigned modulo 2^32.
- `irq` = TCON[2] & TCON[1]. Software clears the status by writing TCON with bit 2 = 0.
- SYSTICK increments every cycle regardless of TCON and wraps from 32'hFFFF_FFFF to 0.
- Simultaneous events:
  - CPU write to TL and timer overflow in the same cycle: the write wins; no reload; status is still set if TCON[1] = 1.
  - CPU write to TCON clearing bit 2 and overflow setting it in the same cycle: the set wins. TCON[0] and TCON[1] take the written values.
  - CPU write to TH during overflow: the reload uses the old TH; TH takes the new value.
  - `MemRead` and `MemWrite` both high: the read returns the pre-write value; the write takes effect at the edge.

## Timing
- Reset values: TH, TL, TCON, `leds`, `digi`, SYSTICK all 0; `irq` = 0; `Device_Read_Data` = 0 while `MemRead` is low.
- Reset mid-count: all state returns to 0 at that edge and the timer stops (TCON[0] = 0).
- Read latency: 0 cycles (combinational from the address and strobes).
- Write latency: the new value is visible on `Device_Read_Data`, `leds` and `digi` in the cycle after the write edge.
- Overflow → `irq`: `irq` rises in the cycle following the edge at which TL == 32'hFFFF_FFFF was sampled with TCON = 3'b011.
- No handshake and no wait states. Every access completes in the cycle it is presented.

## Structure
- Package `peripheral_pkg` holds:
  - the register offsets `OFS_TH` … `OFS_SYSTICK`;
  - the TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_ST`.
- Sub-module `timer_core` holds TH, TL, TCON, the overflow/reload logic and `irq`. Its inputs are the decoded write enables plus write data; its outputs are the register values.
- The top level holds the decode, the LED/DIGI/SYSTICK registers and the read mux.

## Test plan
- Reset, then read every offset with `MemRead` = 1 → all return 0 except SYSTICK. SYSTICK returns the number of edges since reset was released.
- Write TH = 32'hFFFF_FFF0, TL = 32'hFFFF_FFFD, TCON = 3 → TL reaches FFFF_FFFF. The next cycle TL = FFFF_FFF0 and `irq` = 1.
- With `irq` high, write TCON = 3 → `irq` drops the next cycle. After 16 more cycles TL wraps again and `irq` reasserts.
- Write TL = 32'h1234 in the same cycle TL == FFFF_FFFF with TCON = 3 → TL = 32'h1234 and status = 1. In a separate run, write TCON = 3 at overflow → status stays 1.
- Write LED = 32'hFFFF_FFA5 and DIGI = 32'h0000_1E3F → `leds` = 8'hA5 and `digi` = 12'hE3F. Write SYSTICK = 0 → SYSTICK keeps counting.
- Write 32'hDEAD to `BASE_ADDR`+0x02 and to `BASE_ADDR`+0x18 → no register changes. Reads of those addresses return 0.
